// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package adder_pkg;

    // Controller states for the serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the serial adder is meant to be built for.
    localparam int ADDER_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_fa_cell.sv
// One bit slice of the serial adder: a full adder built from two half adders.
// The carry flip-flop that closes the loop lives in the parent.
module serial_fa_cell (
    input  logic a_bit,
    input  logic b_bit,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    logic h1_s;
    logic h1_c;
    logic h2_c;

    // First half adder combines the operand bits, second folds in the carry.
    assign h1_s  = a_bit ^ b_bit;
    assign h1_c  = a_bit & b_bit;
    assign s     = h1_s ^ c_in;
    assign h2_c  = h1_s & c_in;
    assign c_out = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on state and rst; out_valid depends only
// on state. Neither in_valid nor out_ready reaches an output combinationally,
// and a/b are sampled only on the input transfer edge.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > ADDER_MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_t           state_q;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_shift;
    logic             carry_q;
    logic             c_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             last_bit;
    logic             fa_s;
    logic             fa_c;

    serial_fa_cell u_fa (
        .a_bit (a_q[0]),
        .b_bit (b_q[0]),
        .c_in  (c_q),
        .s     (fa_s),
        .c_out (fa_c)
    );

    assign last_bit  = (cnt_q == LAST_BIT);
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;

    // New sum bit enters at the MSB so after WIDTH shifts bit 0 is at the LSB.
    always_comb begin
        sum_shift            = sum_q >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, WIDTH bit steps in RUN, hold in DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, sum shifter, running carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        c_q   <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    sum_q <= sum_shift;
                    c_q   <= fa_c;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_bit) begin
                        carry_q <= fa_c;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases on an 8-bit instance, then random
// traffic with output stalls on an 8-bit and a 1-bit instance in parallel.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst;

  logic       iv8, ir8, ov8, or8, c8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, c1;
  logic [0:0] a1, b1, s1;

  int tests = 0;
  int fails = 0;

  logic [8:0] exp_q8[$];
  logic [1:0] exp_q1[$];

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .carry(c8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n = 0;
    while (!ir8 && n < 40) begin
      tick();
      n++;
    end
    if (!ir8) check("ready8_timeout", 0, 1);
  endtask

  // One full transaction on the 8-bit instance with optional stall / busy noise.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int stall,
                      input bit busy, input string tag);
    logic [8:0] exp;
    int lat;
    int extra;
    exp = {1'b0, a} + {1'b0, b};
    lat = 0;
    extra = 0;
    wait_ready8();
    iv8 = 1'b1; a8 = a; b8 = b; or8 = (stall == 0);
    tick();
    if (busy) begin
      a8 = 8'hFF; b8 = 8'hFF;
    end else begin
      iv8 = 1'b0;
    end
    while (!ov8 && lat < 40) begin
      tick();
      lat++;
    end
    iv8 = 1'b0;
    check({tag, "_latency"}, lat, 8);
    check({tag, "_result"}, {c8, s8}, exp);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_hold_valid"}, ov8, 1);
      check({tag, "_hold_result"}, {c8, s8}, exp);
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    check({tag, "_consumed"}, ov8, 0);
    check({tag, "_ready_after"}, ir8, 1);
    check({tag, "_kept_value"}, {c8, s8}, exp);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ov8) extra++;
    end
    check({tag, "_single_pulse"}, extra, 0);
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
    iv1 = 1'b0; a1 = '0; b1 = '0; or1 = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_in_ready", ir8, 0);
    check("rst_out_valid", ov8, 0);
    check("rst_result", {c8, s8}, 0);
    check("rst_out_valid_w1", ov1, 0);
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'h55;
    tick();
    check("rst_beats_valid", ir8, 0);
    iv8 = 1'b0;
    rst = 1'b0;
    #1;
    check("idle_in_ready", ir8, 1);

    // directed cases
    run8(8'hFF, 8'h01, 0, 1'b0, "ff_01");
    run8(8'h00, 8'h00, 0, 1'b0, "00_00");
    run8(8'hAA, 8'h55, 0, 1'b0, "aa_55");
    run8(8'h80, 8'h80, 5, 1'b0, "backpressure");
    run8(8'h03, 8'h04, 0, 1'b1, "busy_ignore");

    // reset in the middle of an operation
    wait_ready8();
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; or8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov8) seen++;
      tick();
    end
    or8 = 1'b0;
    check("midrst_no_valid", seen, 0);
    check("midrst_cleared", {c8, s8}, 0);
    run8(8'h01, 8'h02, 0, 1'b0, "after_rst");

    // random traffic on both widths
    fork
      begin : rand8
        int acc = 0;
        int res = 0;
        int cyc = 0;
        logic [8:0] e;
        while ((acc < 100 || res < acc) && cyc < 8000) begin
          or8 = ($urandom_range(0, 2) != 0);
          if (ov8 && or8) begin
            if (exp_q8.size() == 0) begin
              check("rand8_unexpected_result", 1, 0);
            end else begin
              e = exp_q8.pop_front();
              check("rand8_sum", {c8, s8}, e);
              res++;
            end
          end
          if (acc < 100 && $urandom_range(0, 3) != 0) begin
            iv8 = 1'b1;
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            if (ir8) begin
              exp_q8.push_back({1'b0, a8} + {1'b0, b8});
              acc++;
            end
          end else begin
            iv8 = 1'b0;
          end
          tick();
          cyc++;
        end
        iv8 = 1'b0; or8 = 1'b0;
        check("rand8_accepts", acc, 100);
        check("rand8_results", res, acc);
      end
      begin : rand1
        int acc = 0;
        int res = 0;
        int cyc = 0;
        logic [1:0] e;
        while ((acc < 100 || res < acc) && cyc < 8000) begin
          or1 = ($urandom_range(0, 2) != 0);
          if (ov1 && or1) begin
            if (exp_q1.size() == 0) begin
              check("rand1_unexpected_result", 1, 0);
            end else begin
              e = exp_q1.pop_front();
              check("rand1_sum", {c1, s1}, e);
              res++;
            end
          end
          if (acc < 100 && $urandom_range(0, 3) != 0) begin
            iv1 = 1'b1;
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            if (ir1) begin
              exp_q1.push_back({1'b0, a1} + {1'b0, b1});
              acc++;
            end
          end else begin
            iv1 = 1'b0;
          end
          tick();
          cyc++;
        end
        iv1 = 1'b0; or1 = 1'b0;
        check("rand1_accepts", acc, 100);
        check("rand1_results", res, acc);
      end
    join

    // WIDTH=1 latency: one RUN edge
    while (!ir1) tick();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; or1 = 1'b0;
    tick();
    iv1 = 1'b0;
    check("w1_not_yet", ov1, 0);
    tick();
    check("w1_valid", ov1, 1);
    check("w1_result", {c1, s1}, 2'b10);
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
    check("w1_consumed", ov1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
